// File: rtl/survivor_memory.sv
// ---------------------------------------------------------------------------
// survivor_memory
//
// Purpose:
//   Survivor path store for the Viterbi decoder. It sits just before the
//   traceback stage. Each accepted ACS column holds the predecessor state of
//   every trellis state. After DEPTH columns the block picks the traceback
//   start node. It then replays the stored columns newest-first, one column
//   per cycle, while o_en_t is high.
//
// Ports:
//   clk           in   clock, all updates on the rising edge
//   rst           in   synchronous, active-low reset
//   i_acs_valid   in   ACS column valid this cycle
//   i_prv_st      in   STATE_W x NUM_STATES predecessor column (state s at
//                      bits [s*STATE_W +: STATE_W])
//   i_pm          in   PM_W x NUM_STATES path metrics (state s at
//                      bits [s*PM_W +: PM_W]), unsigned
//   i_clear       in   releases DONE and starts a new block
//   o_ready       out  high while columns are accepted (FILL)
//   o_sel_node    out  traceback start node
//   o_bck_prv_st  out  survivor column currently addressed by the read pointer
//   o_en_t        out  traceback enable, high for exactly DEPTH cycles/block
//   o_done        out  replay complete
//
// Build option:
//   TERMINATED_TRELLIS_EN - the encoder is flushed to state 0. The start node
//   is forced to 0 and the path metrics are not used. Timing does not change.
// ---------------------------------------------------------------------------
module survivor_memory #(
    parameter int STATE_W    = 2,
    parameter int NUM_STATES = 4,
    parameter int DEPTH      = 64,
    parameter int PM_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_acs_valid,
    input  logic [STATE_W*NUM_STATES-1:0] i_prv_st,
    input  logic [PM_W*NUM_STATES-1:0]    i_pm,
    input  logic                          i_clear,
    output logic                          o_ready,
    output logic [STATE_W-1:0]            o_sel_node,
    output logic [STATE_W*NUM_STATES-1:0] o_bck_prv_st,
    output logic                          o_en_t,
    output logic                          o_done
);

    localparam int COL_W = STATE_W * NUM_STATES;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SELECT = 2'd1,
        ST_READ   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   w_wr_ptr_nxt;
    logic [PTR_W-1:0]   w_rd_ptr_nxt;
    logic               w_wr_en;
    logic               w_last_col;
    logic [STATE_W-1:0] w_sel_final;
    logic [STATE_W-1:0] r_sel_node;
    logic               r_en_t;
    logic               r_done;
    logic               r_ready;

    // Survivor array. It is not reset; every entry is written by the first fill.
    logic [COL_W-1:0]   r_mem [DEPTH];

    // Lowest index of the smallest metric. A strict compare keeps the first
    // minimum, so on a tie the lowest index wins.
    function automatic logic [STATE_W-1:0] argmin_pm(
        input logic [PM_W*NUM_STATES-1:0] pm
    );
        logic [PM_W-1:0]    best;
        logic [STATE_W-1:0] idx;
        best = pm[PM_W-1:0];
        idx  = {STATE_W{1'b0}};
        for (int s = 1; s < NUM_STATES; s++) begin
            if (pm[s*PM_W +: PM_W] < best) begin
                best = pm[s*PM_W +: PM_W];
                idx  = STATE_W'(s);
            end else begin
                idx  = idx;
            end
        end
        return idx;
    endfunction

    // The start node is registered from the metrics of the final column. This
    // makes it stable for the whole SELECT cycle, so the traceback loads it
    // while en_t is still low. No separate metric latch is kept.
`ifdef TERMINATED_TRELLIS_EN
    logic w_unused_pm;
    assign w_unused_pm = ^i_pm;
    assign w_sel_final = {STATE_W{1'b0}};
`else
    assign w_sel_final = argmin_pm(i_pm);
`endif

    // Next-state, pointer and write-enable logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_en      = 1'b0;
        w_last_col   = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (i_acs_valid) begin
                    w_wr_en = 1'b1;
                    if (r_wr_ptr == LAST_PTR) begin
                        // Terminal count: leave the pointer parked at 0.
                        w_last_col   = 1'b1;
                        w_wr_ptr_nxt = {PTR_W{1'b0}};
                        w_state_nxt  = ST_SELECT;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                    end
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_SELECT: begin
                w_rd_ptr_nxt = LAST_PTR;
                w_state_nxt  = ST_READ;
            end
            ST_READ: begin
                if (r_rd_ptr == {PTR_W{1'b0}}) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_rd_ptr_nxt = r_rd_ptr - PTR_ONE;
                end
            end
            ST_DONE: begin
                if (i_clear) begin
                    w_wr_ptr_nxt = {PTR_W{1'b0}};
                    w_state_nxt  = ST_FILL;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt  = ST_FILL;
                w_wr_ptr_nxt = {PTR_W{1'b0}};
                w_rd_ptr_nxt = {PTR_W{1'b0}};
            end
        endcase
    end

    // State, pointers and registered status outputs. The flags follow the
    // next state, so they change on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_FILL;
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_sel_node <= {STATE_W{1'b0}};
            r_en_t     <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            if (w_last_col) begin
                r_sel_node <= w_sel_final;
            end else begin
                r_sel_node <= r_sel_node;
            end
            r_en_t     <= (w_state_nxt == ST_READ);
            r_done     <= (w_state_nxt == ST_DONE);
            r_ready    <= (w_state_nxt == ST_FILL);
        end
    end

    // Survivor column write. Writes are blocked while reset is asserted, so
    // an aborted block cannot disturb the array.
    always_ff @(posedge clk) begin
        if (rst && w_wr_en) begin
            r_mem[r_wr_ptr] <= i_prv_st;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    assign o_bck_prv_st = r_mem[r_rd_ptr];
    assign o_sel_node   = r_sel_node;
    assign o_en_t       = r_en_t;
    assign o_done       = r_done;
    assign o_ready      = r_ready;

endmodule

// File: tb/tb_survivor_memory.sv
module tb_survivor_memory;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_acs_valid;
    logic [7:0]  i_prv_st;
    logic [31:0] i_pm;
    logic        i_clear;
    logic        o_ready;
    logic [1:0]  o_sel_node;
    logic [7:0]  o_bck_prv_st;
    logic        o_en_t;
    logic        o_done;

    int n_cmp = 0;
    int n_err = 0;

    survivor_memory #(
        .STATE_W(2), .NUM_STATES(4), .DEPTH(DEPTH), .PM_W(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_acs_valid  (i_acs_valid),
        .i_prv_st     (i_prv_st),
        .i_pm         (i_pm),
        .i_clear      (i_clear),
        .o_ready      (o_ready),
        .o_sel_node   (o_sel_node),
        .o_bck_prv_st (o_bck_prv_st),
        .o_en_t       (o_en_t),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pm;
        int          seed;
        bit          gapped;
        bit          bp;
        logic [1:0]  exp_min;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Column k, state s holds (k + s*seed) mod 4.
    function automatic logic [7:0] make_col(input int k, input int seed);
        logic [7:0] c;
        for (int s = 0; s < 4; s++) c[s*2 +: 2] = 2'(k + s*seed);
        return c;
    endfunction

    function automatic logic [31:0] pm_pack(input logic [7:0] a0, input logic [7:0] a1,
                                            input logic [7:0] a2, input logic [7:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [1:0] exp_sel(input logic [1:0] m);
`ifdef TERMINATED_TRELLIS_EN
        return 2'd0;
`else
        return m;
`endif
    endfunction

    // Fill one block, then check the replay. If abort_at >= 0, reset is
    // asserted at that replay cycle and the block is abandoned.
    task automatic run_block(input vec_t v, input int abort_at);
        logic [1:0] es;
        es = exp_sel(v.exp_min);
        chk("ready_at_fill", 32'(o_ready), 32'd1);
        for (int k = 0; k < DEPTH; k++) begin
            i_acs_valid = 1'b1;
            i_prv_st    = make_col(k, v.seed);
            i_pm        = (k == DEPTH-1) ? v.pm : $urandom;
            tick();
            if (k == DEPTH-2) chk("ready_before_last", 32'(o_ready), 32'd1);
            if (v.gapped && k != DEPTH-1) begin
                i_acs_valid = 1'b0;
                i_prv_st    = ~make_col(k, v.seed);
                i_pm        = $urandom;
                tick();
                chk("ready_in_gap", 32'(o_ready), 32'd1);
            end
        end
        // SELECT cycle
        chk("ready_select", 32'(o_ready), 32'd0);
        chk("en_t_select", 32'(o_en_t), 32'd0);
        chk("done_select", 32'(o_done), 32'd0);
        i_acs_valid = v.bp;
        i_prv_st    = 8'($urandom);
        i_pm        = $urandom;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == abort_at) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
                i_acs_valid = 1'b0;
                chk("abort_en_t", 32'(o_en_t), 32'd0);
                chk("abort_done", 32'(o_done), 32'd0);
                chk("abort_ready", 32'(o_ready), 32'd1);
                chk("abort_sel", 32'(o_sel_node), 32'd0);
                return;
            end
            chk("replay_en_t", 32'(o_en_t), 32'd1);
            chk("replay_col", 32'(o_bck_prv_st), 32'(make_col(DEPTH-1-i, v.seed)));
            chk("replay_sel", 32'(o_sel_node), 32'(es));
            chk("replay_ready", 32'(o_ready), 32'd0);
            i_prv_st = 8'($urandom);
            tick();
        end
        // DONE
        chk("done_en_t", 32'(o_en_t), 32'd0);
        chk("done_flag", 32'(o_done), 32'd1);
        chk("done_ready", 32'(o_ready), 32'd0);
        chk("done_col", 32'(o_bck_prv_st), 32'(make_col(0, v.seed)));
        repeat (3) begin
            i_prv_st = 8'($urandom);
            tick();
        end
        chk("done_hold_flag", 32'(o_done), 32'd1);
        chk("done_hold_en_t", 32'(o_en_t), 32'd0);
        chk("done_hold_col", 32'(o_bck_prv_st), 32'(make_col(0, v.seed)));
        chk("done_hold_sel", 32'(o_sel_node), 32'(es));
        i_acs_valid = 1'b0;
        i_clear     = 1'b1;
        tick();
        i_clear     = 1'b0;
        chk("clear_done", 32'(o_done), 32'd0);
        chk("clear_ready", 32'(o_ready), 32'd1);
        chk("clear_en_t", 32'(o_en_t), 32'd0);
    endtask

    initial begin
        vec_t v_abort;
        vecs[0] = '{pm_pack(8'd9,   8'd3,   8'd7,  8'd3),  0, 1'b0, 1'b0, 2'd1};
        vecs[1] = '{pm_pack(8'd5,   8'd5,   8'd5,  8'd5),  1, 1'b1, 1'b0, 2'd0};
        vecs[2] = '{pm_pack(8'd200, 8'd100, 8'd50, 8'd49), 3, 1'b0, 1'b1, 2'd3};
        vecs[3] = '{pm_pack(8'd50,  8'd1,   8'd2,  8'd3),  2, 1'b1, 1'b0, 2'd1};
        vecs[4] = '{pm_pack(8'd255, 8'd255, 8'd0,  8'd0),  1, 1'b0, 1'b1, 2'd2};

        rst = 1'b0;
        i_acs_valid = 1'b0;
        i_clear = 1'b0;
        i_prv_st = 8'd0;
        i_pm = 32'd0;
        tick();
        tick();
        rst = 1'b1;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_en_t", 32'(o_en_t), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_sel", 32'(o_sel_node), 32'd0);

        // Idle: valid low (clear toggling is ignored outside DONE)
        for (int c = 0; c < 100; c++) begin
            i_clear  = c[0];
            i_prv_st = 8'($urandom);
            i_pm     = $urandom;
            tick();
        end
        i_clear = 1'b0;
        chk("idle_ready", 32'(o_ready), 32'd1);
        chk("idle_en_t", 32'(o_en_t), 32'd0);
        chk("idle_done", 32'(o_done), 32'd0);
        chk("idle_sel", 32'(o_sel_node), 32'd0);

        // Back-to-back blocks from the table
        for (int i = 0; i < 5; i++) run_block(vecs[i], -1);

        // Reset during replay, then a clean block
        v_abort = vecs[3];
        run_block(v_abort, 20);
        run_block(vecs[0], -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/survivor_memory.md
Name: survivor_memory

Overview:
- Sits directly upstream of the traceback stage in the Viterbi decoder.
- Captures one survivor column per trellis step from the ACS unit: the predecessor state for every state.
- After TRACEBACK_DEPTH columns, selects the best final node from the last path metrics. It then replays the stored columns newest-first, one per cycle, under an enable strobe that drives the traceback unit's en_t, i_sel_node and i_bck_prv_st.

Parameters:
- STATE_W, 2, bits per state index (register count of the encoder).
- NUM_STATES, 4, number of trellis states; equals 2**STATE_W.
- DEPTH, 64, columns per block (trellis steps); must satisfy DEPTH*2 <= 128.
- PM_W, 8, path metric width, unsigned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- i_acs_valid  in  1  ACS column valid this cycle.
- i_prv_st  in  STATE_W x NUM_STATES  predecessor state for each state at this step.
- i_pm  in  PM_W x NUM_STATES  path metrics after this step.
- i_clear  in  1  releases DONE and starts a new block.
- o_ready  out  1  high while columns are accepted (FILL state).
- o_sel_node  out  STATE_W  start node for traceback.
- o_bck_prv_st  out  STATE_W x NUM_STATES  survivor column currently replayed.
- o_en_t  out  1  traceback enable; high for exactly DEPTH cycles per block.
- o_done  out  1  replay complete.

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to FILL; write pointer and read pointer go to 0.
  - o_sel_node=0, o_en_t=0, o_done=0, o_ready=1.
  - The survivor array is not reset.
  - Reset in any state aborts the block immediately; a partially filled or partially replayed block is discarded.
- Storage: DEPTH x NUM_STATES x STATE_W register array.
- FILL:
  - On i_acs_valid=1, column[wr_ptr] <= i_prv_st and wr_ptr increments.
  - When the accepted column is number DEPTH-1, also latch i_pm of that same cycle and go to SELECT.
  - i_acs_valid=0 holds all state; gaps are allowed.
- SELECT (1 cycle):
  - o_ready=0.
  - o_sel_node <= index of the minimum latched path metric; on ties the lowest index wins.
  - rd_ptr <= DEPTH-1, then go to READ.
  - o_sel_node is therefore valid at least one cycle before o_en_t rises, which the traceback needs: it loads its start node while en_t=0.
- READ (DEPTH cycles):
  - o_en_t=1.
  - o_bck_prv_st is driven combinationally from column[rd_ptr].
  - rd_ptr decrements each cycle, so the first en_t cycle presents column DEPTH-1 and the last presents column 0.
  - When rd_ptr==0, go to DONE next cycle.
  - o_sel_node is held stable throughout.
- DONE:
  - o_en_t=0, o_done=1; outputs held.
  - i_clear=1: o_done <= 0, wr_ptr <= 0, go to FILL.
  - i_clear outside DONE is ignored.
- i_acs_valid outside FILL is ignored and columns are dropped; the upstream unit must honour o_ready.
- o_bck_prv_st outside READ: drives column[rd_ptr]. The value is don't-care for the consumer, but must be X-free after the first fill.
- Pointers are ceil(log2(DEPTH)) bits and never wrap: the FILL exit and the READ exit fire at their terminal counts.
- Latency: the last column is accepted at cycle N, SELECT runs at N+1, o_en_t is high from N+2 through N+1+DEPTH, and o_done rises at N+2+DEPTH.

Optional Feature:
- Macro: TERMINATED_TRELLIS_EN.
- Defined: the encoder is flushed to state 0; SELECT forces o_sel_node=0, i_pm is ignored and no metric latch is built. Timing is unchanged.
- Undefined: o_sel_node is the minimum-metric argmin as described under Behaviour.

Test Plan:
- Reset then idle: rst low 2 cycles -> o_ready=1, o_en_t=0, o_done=0, o_sel_node=0; hold i_acs_valid=0 for 100 cycles -> no state change.
- Fill and replay (DEPTH=64):
  - Stimulus: 64 valid columns, column k has all entries = k mod 4; final i_pm={9,3,7,3}.
  - Response: o_sel_node=1 (tie, lowest index); o_en_t high exactly 64 cycles; o_bck_prv_st entries sequence 3,2,1,0,... ending at 0; o_done rises the cycle after.
- Gapped input: i_acs_valid toggled 1/0 for 64 accepted columns -> only valid cycles stored; SELECT entered the cycle after the 64th valid column.
- Backpressure: i_acs_valid held high through SELECT, READ and DONE -> no array write; last replayed column unchanged; o_ready=0 throughout.
- Reset mid-READ: rst low at replay cycle 20 -> o_en_t=0 next cycle, state FILL, o_done=0; the following block of 64 columns replays correctly.
- With TERMINATED_TRELLIS_EN: final i_pm={50,1,2,3} -> o_sel_node=0. Back-to-back blocks: i_clear in DONE -> FILL accepts a new block and the second replay matches its data.
